// File: rtl/cmp_feeder_if.sv
// Handshake bundle between the data feeder and the compare ALU (cmpalu).
// The feeder drives column/row data with one-cycle ready strobes and the
// launch pulse. The ALU drives its next-column/next-row requests, the done
// flag and the 16-bit result.
//   master : feeder side  (drives bitcolumn, bitrow, *ready, cmp_start)
//   slave  : cmpalu side  (drives nextcolumn, nextrow, done, result)
interface cmp_feeder_if #(
  parameter int COL_W = 64,
  parameter int ROW_W = 24
);
  logic             nextcolumn;
  logic             nextrow;
  logic             done;
  logic [15:0]      result;
  logic [COL_W-1:0] bitcolumn;
  logic [ROW_W-1:0] bitrow;
  logic             nextcolumnready;
  logic             nextrowready;
  logic             cmp_start;

  modport master (
    input  nextcolumn, nextrow, done, result,
    output bitcolumn, bitrow, nextcolumnready, nextrowready, cmp_start
  );

  modport slave (
    output nextcolumn, nextrow, done, result,
    input  bitcolumn, bitrow, nextcolumnready, nextrowready, cmp_start
  );
endinterface

// File: rtl/cmp_feeder.sv
// Data-supply end of the compare-ALU handshake. Fetches image columns and
// template rows from a shared single-port synchronous RAM, answers cmpalu
// requests with data plus a one-cycle ready strobe, launches the compare
// and captures the result when cmpalu reports done.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle job start (honoured only while idle)
//   col_base/num_cols first column address and column count, latched on start
//   row_base/num_rows first row address and row count, latched on start
//   mem_rd/mem_addr   RAM read strobe and address
//   mem_rdata         RAM data, valid the cycle after mem_rd
//   alu               cmpalu handshake (master side)
//   res_out/res_valid captured result and its one-cycle strobe
//   busy              high whenever a job is in progress
module cmp_feeder #(
  parameter int ADDR_W = 10,
  parameter int COL_W  = 64,
  parameter int ROW_W  = 24,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [CNT_W-1:0]  num_cols,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [CNT_W-1:0]  num_rows,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COL_W-1:0]  mem_rdata,
  cmp_feeder_if.master      alu,
  output logic [15:0]       res_out,
  output logic              res_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, PRIME_COL, PRIME_ROW, LAUNCH, SERVE, RD_COL, RD_ROW, CAPTURE
  } state_e;

  state_e             state_q;
  logic [1:0]         phase_q;
  logic [ADDR_W-1:0]  colBase_q, rowBase_q;
  logic [CNT_W-1:0]   numCols_q, numRows_q;
  logic [CNT_W-1:0]   colIdx_q, rowIdx_q;
  logic               pendCol_q, pendRow_q;
  logic               pad_q;
  logic               memRd_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [COL_W-1:0]   bitCol_q;
  logic [ROW_W-1:0]   bitRow_q;
  logic               colReady_q, rowReady_q, cmpStart_q;
  logic [15:0]        resOut_q;
  logic               resValid_q, busy_q;

  logic               colAvail, rowAvail, clrCol, clrRow;
  logic [ADDR_W-1:0]  colAddr, rowAddr;

  assign colAvail = (colIdx_q < numCols_q);
  assign rowAvail = (rowIdx_q < numRows_q);
  assign colAddr  = colBase_q + ADDR_W'(colIdx_q);
  assign rowAddr  = rowBase_q + ADDR_W'(rowIdx_q);
  // A request is retired in the cycle its ready strobe is shown.
  assign clrCol   = (state_q == RD_COL) && (phase_q == 2'd2);
  assign clrRow   = (state_q == RD_ROW) && (phase_q == 2'd2);

  // Each fetch runs three phases: 0 = RAM read issued, 1 = RAM data
  // registered (or zero padding once the index passes the count),
  // 2 = ready strobe. pad_q remembers that the fetch is past the end so no
  // RAM read is issued and zeros are loaded; the index then saturates.
  // Pending flags are sticky: a new request in the retiring cycle wins over
  // the clear so it is never lost, and repeats while pending merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      colBase_q  <= '0;
      rowBase_q  <= '0;
      numCols_q  <= '0;
      numRows_q  <= '0;
      colIdx_q   <= '0;
      rowIdx_q   <= '0;
      pendCol_q  <= 1'b0;
      pendRow_q  <= 1'b0;
      pad_q      <= 1'b0;
      memRd_q    <= 1'b0;
      memAddr_q  <= '0;
      bitCol_q   <= '0;
      bitRow_q   <= '0;
      colReady_q <= 1'b0;
      rowReady_q <= 1'b0;
      cmpStart_q <= 1'b0;
      resOut_q   <= '0;
      resValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      memRd_q    <= 1'b0;
      colReady_q <= 1'b0;
      rowReady_q <= 1'b0;
      cmpStart_q <= 1'b0;
      resValid_q <= 1'b0;

      if (state_q == IDLE) begin
        pendCol_q <= 1'b0;
        pendRow_q <= 1'b0;
      end else begin
        pendCol_q <= (pendCol_q & ~clrCol) | alu.nextcolumn;
        pendRow_q <= (pendRow_q & ~clrRow) | alu.nextrow;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            colBase_q <= col_base;
            rowBase_q <= row_base;
            numCols_q <= num_cols;
            numRows_q <= num_rows;
            colIdx_q  <= '0;
            rowIdx_q  <= '0;
            phase_q   <= '0;
            memRd_q   <= (num_cols != '0);
            memAddr_q <= col_base;
            pad_q     <= (num_cols == '0);
            busy_q    <= 1'b1;
            state_q   <= PRIME_COL;
          end
        end
        PRIME_COL, RD_COL: begin
          case (phase_q)
            2'd0: phase_q <= 2'd1;
            2'd1: begin
              bitCol_q   <= pad_q ? '0 : mem_rdata;
              if (!pad_q) colIdx_q <= colIdx_q + 1'b1;
              colReady_q <= 1'b1;
              phase_q    <= 2'd2;
            end
            default: begin
              phase_q <= '0;
              if (state_q == PRIME_COL) begin
                memRd_q   <= rowAvail;
                memAddr_q <= rowAddr;
                pad_q     <= !rowAvail;
                state_q   <= PRIME_ROW;
              end else begin
                state_q <= SERVE;
              end
            end
          endcase
        end
        PRIME_ROW, RD_ROW: begin
          case (phase_q)
            2'd0: phase_q <= 2'd1;
            2'd1: begin
              bitRow_q   <= pad_q ? '0 : mem_rdata[ROW_W-1:0];
              if (!pad_q) rowIdx_q <= rowIdx_q + 1'b1;
              rowReady_q <= 1'b1;
              phase_q    <= 2'd2;
            end
            default: begin
              phase_q <= '0;
              if (state_q == PRIME_ROW) begin
                cmpStart_q <= 1'b1;
                state_q    <= LAUNCH;
              end else begin
                state_q <= SERVE;
              end
            end
          endcase
        end
        LAUNCH: state_q <= SERVE;
        // done outranks pending fetches; columns outrank rows.
        SERVE: begin
          if (alu.done) begin
            resOut_q   <= alu.result;
            resValid_q <= 1'b1;
            state_q    <= CAPTURE;
          end else if (pendCol_q) begin
            memRd_q   <= colAvail;
            memAddr_q <= colAddr;
            pad_q     <= !colAvail;
            phase_q   <= '0;
            state_q   <= RD_COL;
          end else if (pendRow_q) begin
            memRd_q   <= rowAvail;
            memAddr_q <= rowAddr;
            pad_q     <= !rowAvail;
            phase_q   <= '0;
            state_q   <= RD_ROW;
          end
        end
        CAPTURE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd              = memRd_q;
  assign mem_addr            = memAddr_q;
  assign alu.bitcolumn       = bitCol_q;
  assign alu.bitrow          = bitRow_q;
  assign alu.nextcolumnready = colReady_q;
  assign alu.nextrowready    = rowReady_q;
  assign alu.cmp_start       = cmpStart_q;
  assign res_out             = resOut_q;
  assign res_valid           = resValid_q;
  assign busy                = busy_q;

endmodule
